cache_fill_ctrl: RTL and testbench



---
 rtl/cache_fill_ctrl_if.sv | 33 +++
 rtl/cache_fill_ctrl.sv | 133 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Bundle of the miss, memory-request and array-write signals around the cache fill controller.
// The controller connects through the master modport; the miss source and memory model use slave.
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
);
    localparam int OFF_W = $clog2(WORDS);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;
    logic              memory_read;
    logic [ADDR_W-1:0] memory_address;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;
    logic              write_data_array;
    logic [OFF_W-1:0]  write_word_offset;
    logic [DATA_W-1:0] write_data;
    logic              write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, memory_read, memory_address, write_data_array,
               write_word_offset, write_data, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, memory_read, memory_address, write_data_array,
               write_word_offset, write_data, write_tag_array
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: on a miss, streams WORDS read requests and writes returning data.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start the fill at the missing word (wrap-around).
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    parameter int BYTES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_fill_ctrl_if.master  bus
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int BYTE_W = $clog2(BYTES);
    localparam int CNT_W  = OFF_W + 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS * BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  rq_r;
    logic [CNT_W-1:0]  rs_r;
    logic [ADDR_W-1:0] base_r;
    logic [OFF_W-1:0]  start_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [ADDR_W-1:0] miss_base_s;
    logic [OFF_W-1:0]  miss_start_s;
    logic [OFF_W-1:0]  req_idx_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic              read_s;
    logic              busy_s;
    logic              wr_data_s;
    logic              wr_tag_s;
    logic [OFF_W-1:0]  wr_off_s;

    assign miss_base_s = bus.miss_address & ~BLK_MASK;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign miss_start_s = OFF_W'((bus.miss_address & BLK_MASK) >> BYTE_W);
`else
    assign miss_start_s = {OFF_W{1'b0}};
`endif

    // Word index arithmetic is OFF_W wide, so the address wraps inside the block.
    assign req_idx_s  = start_r + rq_r[OFF_W-1:0];
    assign req_addr_s = base_r | (ADDR_W'(req_idx_s) << BYTE_W);

    assign bus.fsm_busy          = busy_s;
    assign bus.memory_read       = read_s;
    assign bus.memory_address    = read_s ? req_addr_s : last_addr_r;
    assign bus.write_data_array  = wr_data_s;
    assign bus.write_tag_array   = wr_tag_s;
    assign bus.write_word_offset = wr_off_s;
    assign bus.write_data        = bus.memory_data;

    // Next-state and fill outputs; responses consumed in the same cycle they are valid.
    always_comb begin
        state_s   = state_r;
        busy_s    = 1'b0;
        read_s    = 1'b0;
        wr_data_s = 1'b0;
        wr_tag_s  = 1'b0;
        wr_off_s  = {OFF_W{1'b0}};
        case (state_r)
            IDLE: begin
                busy_s = bus.miss_detected;
                if (bus.miss_detected) begin
                    state_s = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                busy_s = 1'b1;
                read_s = (rq_r < CNT_W'(WORDS));
                if (bus.memory_data_valid) begin
                    wr_data_s = 1'b1;
                    wr_off_s  = start_r + rs_r[OFF_W-1:0];
                    if (rs_r == CNT_W'(WORDS - 1)) begin
                        wr_tag_s = 1'b1;
                        state_s  = IDLE;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fill context: block base, start word, request/response counters and held address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_r        <= {CNT_W{1'b0}};
            rs_r        <= {CNT_W{1'b0}};
            base_r      <= {ADDR_W{1'b0}};
            start_r     <= {OFF_W{1'b0}};
            last_addr_r <= {ADDR_W{1'b0}};
        end else if (state_r == IDLE) begin
            if (bus.miss_detected) begin
                base_r  <= miss_base_s;
                start_r <= miss_start_s;
                rq_r    <= {CNT_W{1'b0}};
                rs_r    <= {CNT_W{1'b0}};
            end
        end else begin
            if (read_s) begin
                rq_r        <= rq_r + CNT_W'(1);
                last_addr_r <= req_addr_s;
            end
            if (bus.memory_data_valid) begin
                rs_r <= rs_r + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized self-checking bench for cache_fill_ctrl against a block-fill reference model.
module tb_cache_fill_ctrl;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 8;
    localparam int BYTES  = 2;
    localparam int OFF_W  = $clog2(WORDS);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

    cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .BYTES(BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    function automatic int blk_base(input int a);
        return a - (a % (WORDS * BYTES));
    endfunction

    function automatic int fill_start(input int a);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        return (a / BYTES) % WORDS;
`else
        return 0;
`endif
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int a, input int i);
        return ADDR_W'(blk_base(a) + ((fill_start(a) + i) % WORDS) * BYTES);
    endfunction

    // One fill: memory model answers outstanding requests in order with random gaps.
    task automatic run_fill(input logic [ADDR_W-1:0] a, input int max_gap, input bit hold, input int abort_after);
        int nreq, nresp, pend, gap, ntag, cyc;
        bit v;
        logic [DATA_W-1:0] d;
        nreq = 0; nresp = 0; pend = 0; gap = 0; ntag = 0; cyc = 0; d = '0;
        @(posedge clk); #1;
        bus.miss_detected = 1'b1;
        bus.miss_address = a;
        bus.memory_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fsm_busy !== 1'b1) begin errors++; $display("FAIL busy_on_miss got=%b exp=1", bus.fsm_busy); end
        checks++;
        if (bus.memory_read !== 1'b0) begin errors++; $display("FAIL idle_read got=%b exp=0", bus.memory_read); end
        while (nresp < WORDS && !(abort_after > 0 && nresp == abort_after) && cyc < 200) begin
            @(posedge clk); #1;
            if (hold) bus.miss_address = ADDR_W'($urandom);
            else bus.miss_detected = 1'b0;
            v = (pend > 0 && gap == 0);
            if (v) begin
                d = DATA_W'($urandom);
                gap = $urandom_range(0, max_gap);
            end else if (gap > 0) begin
                gap--;
            end
            bus.memory_data_valid = v;
            bus.memory_data = d;
            @(negedge clk);
            checks++;
            if (bus.fsm_busy !== 1'b1) begin errors++; $display("FAIL fill_busy cyc=%0d got=%b exp=1", cyc, bus.fsm_busy); end
            checks++;
            if (bus.memory_read !== (cyc < WORDS)) begin errors++; $display("FAIL read_strobe cyc=%0d got=%b exp=%b", cyc, bus.memory_read, cyc < WORDS); end
            if (bus.memory_read === 1'b1) begin
                checks++;
                if (bus.memory_address !== exp_addr(a, nreq)) begin
                    errors++; $display("FAIL req_addr n=%0d got=%h exp=%h", nreq, bus.memory_address, exp_addr(a, nreq));
                end
                nreq++; pend++;
            end
            checks++;
            if (bus.write_data_array !== v) begin errors++; $display("FAIL data_we cyc=%0d got=%b exp=%b", cyc, bus.write_data_array, v); end
            if (v) begin
                checks++;
                if (bus.write_word_offset !== OFF_W'((fill_start(a) + nresp) % WORDS)) begin
                    errors++; $display("FAIL word_offset n=%0d got=%0d exp=%0d", nresp, bus.write_word_offset, (fill_start(a) + nresp) % WORDS);
                end
                checks++;
                if (bus.write_data !== d) begin errors++; $display("FAIL write_data got=%h exp=%h", bus.write_data, d); end
                checks++;
                if (bus.write_tag_array !== (nresp == WORDS - 1)) begin
                    errors++; $display("FAIL tag_we n=%0d got=%b exp=%b", nresp, bus.write_tag_array, nresp == WORDS - 1);
                end
                if (bus.write_tag_array === 1'b1) ntag++;
                nresp++; pend--;
            end else begin
                checks++;
                if (bus.write_tag_array !== 1'b0) begin errors++; $display("FAIL tag_idle got=%b exp=0", bus.write_tag_array); end
            end
            cyc++;
        end
        if (cyc >= 200) begin
            errors++; checks++;
            $display("FAIL fill_timeout resp=%0d exp=%0d", nresp, WORDS);
        end else if (abort_after == 0) begin
            checks++;
            if (ntag != 1) begin errors++; $display("FAIL tag_count got=%0d exp=1", ntag); end
        end
    endtask

    // After a completed fill with miss low: idle, address held at the last request.
    task automatic check_idle_after(input logic [ADDR_W-1:0] a);
        @(posedge clk); #1;
        bus.memory_data_valid = 1'b0;
        bus.miss_detected = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL busy_after got=%b exp=0", bus.fsm_busy); end
        checks++;
        if (bus.memory_read !== 1'b0) begin errors++; $display("FAIL read_after got=%b exp=0", bus.memory_read); end
        checks++;
        if (bus.memory_address !== exp_addr(a, WORDS - 1)) begin
            errors++; $display("FAIL addr_hold got=%h exp=%h", bus.memory_address, exp_addr(a, WORDS - 1));
        end
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if ({bus.memory_read, bus.write_data_array, bus.write_tag_array, bus.write_word_offset, bus.memory_address} !== '0) begin
            errors++;
            $display("FAIL %s rd=%b wd=%b wt=%b off=%0d addr=%h exp=all-zero", tag, bus.memory_read,
                     bus.write_data_array, bus.write_tag_array, bus.write_word_offset, bus.memory_address);
        end
    endtask

    task automatic test_reset();
        bus.miss_detected = 1'b0;
        bus.miss_address = '0;
        bus.memory_data = '0;
        bus.memory_data_valid = 1'b0;
        #2;
        check_quiet("reset_outputs");
        checks++;
        if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", bus.fsm_busy); end
        bus.miss_detected = 1'b1;
        #1;
        checks++;
        if (bus.fsm_busy !== 1'b1) begin errors++; $display("FAIL reset_busy1 got=%b exp=1", bus.fsm_busy); end
        bus.miss_detected = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_seq_fill();
        run_fill(16'h1236, 3, 1'b0, 0);
        check_idle_after(16'h1236);
    endtask

    task automatic test_top_wrap();
        run_fill(16'hFFFE, 1, 1'b0, 0);
        check_idle_after(16'hFFFE);
    endtask

    task automatic test_random_fills();
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < 6; k++) begin
            a = ADDR_W'($urandom);
            run_fill(a, 5, 1'b0, 0);
            check_idle_after(a);
        end
    endtask

    task automatic test_idle_valid();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.memory_data_valid = 1'b1;
            bus.memory_data = DATA_W'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.write_data_array, bus.write_tag_array, bus.memory_read} !== 3'b000) begin
                errors++; $display("FAIL idle_valid wd=%b wt=%b rd=%b exp=000", bus.write_data_array, bus.write_tag_array, bus.memory_read);
            end
        end
        bus.memory_data_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a0, a1;
        a0 = ADDR_W'($urandom);
        a1 = ADDR_W'($urandom);
        run_fill(a0, 5, 1'b1, 0);
        run_fill(a1, 5, 1'b1, 0);
        check_idle_after(a1);
    endtask

    task automatic test_reset_mid_fill();
        run_fill(16'h4A52, 2, 1'b0, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.memory_data_valid = 1'b0;
        bus.miss_detected = 1'b0;
        #1;
        check_quiet("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.memory_data_valid = 1'b1;
            bus.memory_data = DATA_W'($urandom);
            @(negedge clk);
            check_quiet("stray_resp");
            checks++;
            if (bus.fsm_busy !== 1'b0) begin errors++; $display("FAIL stray_busy got=%b exp=0", bus.fsm_busy); end
        end
        bus.memory_data_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq_fill();
        test_top_wrap();
        test_random_fills();
        test_idle_valid();
        test_back_to_back();
        test_reset_mid_fill();
        test_seq_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
